// File: rtl/camera_cfg_seq_pkg.sv
// Shared definitions for the camera register-initialisation sequencer:
// state encoding, delay-marker address and debug word layout.
package cam_cfg_defs;

   typedef enum logic [3:0] {
      StSettle = 4'd0,
      StFetch  = 4'd1,
      StDelay  = 4'd2,
      StWrReq  = 4'd3,
      StWrWait = 4'd4,
      StRdReq  = 4'd5,
      StRdWait = 4'd6,
      StRetry  = 4'd7,
      StNext   = 4'd8,
      StDone   = 4'd9,
      StError  = 4'd10
   } cfg_state_e;

   localparam logic [7:0] DELAY_MARKER = 8'hFF;

   // {state[7:0], index[7:0], retry[3:0], 4'b0, last_rd[7:0]}
   function automatic logic [31:0] pack_debug(input cfg_state_e st, input logic [7:0] idx,
                                              input logic [3:0] rty, input logic [7:0] rd);
      return {4'b0, st, idx, rty, 4'b0, rd};
   endfunction

endpackage

// File: rtl/camera_cfg_rom.sv
// Combinational sensor configuration table: index -> {reg_addr, reg_data}.
// The entry at DELAY_ENTRY is replaced by a delay marker.
module camera_cfg_rom
   import cam_cfg_defs::*;
#(
   parameter logic [7:0] DELAY_ENTRY = DELAY_MARKER
) (
   input  logic [7:0] index,
   output logic [7:0] reg_addr,
   output logic [7:0] reg_data
);

   // Top address bit kept clear so an ordinary entry can never alias the marker.
   always_comb begin
      reg_addr = {1'b0, index[6:0]};
      reg_data = index * 8'd3 + 8'h13;
      if (index == DELAY_ENTRY) begin
         reg_addr = DELAY_MARKER;
      end
   end

endmodule

// File: rtl/camera_cfg_seq.sv
// Camera register-initialisation sequencer: settles, walks the config table,
// writes (and optionally reads back) each register through the SCCB/I2C driver.
module camera_cfg_seq
   import cam_cfg_defs::*;
#(
   parameter logic [15:0] NUM_REGS    = 16'd64,
   parameter logic [19:0] SETTLE_CYC  = 20'd1000,
   parameter logic [19:0] DELAY_CYC   = 20'd500,
   parameter logic [2:0]  MAX_RETRY   = 3'd3,
   parameter logic        VERIFY      = 1'b0,
   parameter logic        ACK_OK      = 1'b0,
   parameter logic [7:0]  DELAY_ENTRY = DELAY_MARKER
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic        iic_wr_en,
   output logic        iic_rd_en,
   output logic [7:0]  iic_addr,
   output logic [7:0]  iic_wr_data,
   input  logic        iic_work_done,
   input  logic        iic_ack,
   input  logic [7:0]  iic_rd_data,
   output logic        cfg_busy,
   output logic        cfg_done,
   output logic        cfg_err,
   output logic [7:0]  err_index,
   output logic [31:0] debug_out
);

   cfg_state_e  state;
   logic [7:0]  index;
   logic [3:0]  retry;
   logic [7:0]  last_rd;
   logic [19:0] wait_cnt;
   logic [20:0] wait_nxt;
   logic [7:0]  rom_addr;
   logic [7:0]  rom_data;

   camera_cfg_rom #(
      .DELAY_ENTRY(DELAY_ENTRY)
   ) u_rom (
      .index   (index),
      .reg_addr(rom_addr),
      .reg_data(rom_data)
   );

   // One extra bit so the >= compare stays correct even at the counter limit.
   assign wait_nxt  = {1'b0, wait_cnt} + 21'd1;
   assign debug_out = pack_debug(state, index, retry, last_rd);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= StSettle;
         index       <= 8'd0;
         retry       <= 4'd0;
         last_rd     <= 8'd0;
         wait_cnt    <= 20'd0;
         iic_wr_en   <= 1'b0;
         iic_rd_en   <= 1'b0;
         iic_addr    <= 8'd0;
         iic_wr_data <= 8'd0;
         cfg_busy    <= 1'b1;
         cfg_done    <= 1'b0;
         cfg_err     <= 1'b0;
         err_index   <= 8'd0;
      end else begin
         unique case (state)
            StSettle: begin
               if (wait_nxt >= {1'b0, SETTLE_CYC}) begin
                  wait_cnt <= 20'd0;
                  state    <= StFetch;
               end else begin
                  wait_cnt <= wait_nxt[19:0];
               end
            end
            StFetch: begin
               iic_addr    <= rom_addr;
               iic_wr_data <= rom_data;
               if (rom_addr == DELAY_MARKER) begin
                  state <= StDelay;
               end else begin
                  iic_wr_en <= 1'b1;
                  state     <= StWrReq;
               end
            end
            StDelay: begin
               if (wait_nxt >= {1'b0, DELAY_CYC}) begin
                  wait_cnt <= 20'd0;
                  state    <= StNext;
               end else begin
                  wait_cnt <= wait_nxt[19:0];
               end
            end
            // A low done flag means the driver has taken the request.
            StWrReq: begin
               if (!iic_work_done) begin
                  iic_wr_en <= 1'b0;
                  state     <= StWrWait;
               end
            end
            StWrWait: begin
               if (iic_work_done) begin
                  if (iic_ack != ACK_OK) begin
                     state <= StRetry;
                  end else if (VERIFY) begin
                     iic_rd_en <= 1'b1;
                     state     <= StRdReq;
                  end else begin
                     state <= StNext;
                  end
               end
            end
            StRdReq: begin
               if (!iic_work_done) begin
                  iic_rd_en <= 1'b0;
                  state     <= StRdWait;
               end
            end
            StRdWait: begin
               if (iic_work_done) begin
                  last_rd <= iic_rd_data;
                  if ((iic_ack != ACK_OK) || (iic_rd_data != iic_wr_data)) begin
                     state <= StRetry;
                  end else begin
                     state <= StNext;
                  end
               end
            end
            StRetry: begin
               retry <= retry + 4'd1;
               if (retry >= {1'b0, MAX_RETRY}) begin
                  err_index <= index;
                  cfg_busy  <= 1'b0;
                  cfg_err   <= 1'b1;
                  state     <= StError;
               end else begin
                  iic_wr_en <= 1'b1;
                  state     <= StWrReq;
               end
            end
            StNext: begin
               retry <= 4'd0;
               index <= index + 8'd1;
               if (({8'd0, index} + 16'd1) >= NUM_REGS) begin
                  cfg_busy <= 1'b0;
                  cfg_done <= 1'b1;
                  state    <= StDone;
               end else begin
                  state <= StFetch;
               end
            end
            StDone, StError: begin
               if (start) begin
                  cfg_done <= 1'b0;
                  cfg_err  <= 1'b0;
                  cfg_busy <= 1'b1;
                  index    <= 8'd0;
                  retry    <= 4'd0;
                  wait_cnt <= 20'd0;
                  state    <= StSettle;
               end
            end
            default: state <= StSettle;
         endcase
      end
   end

endmodule

// File: tb/tb_camera_cfg_seq.sv
// Bench for camera_cfg_seq: two DUT configurations, a behavioural 40-cycle driver,
// and a transfer-list predictor built from the sequencing rules.
module tb_camera_cfg_seq;

   localparam int XFER   = 40;
   localparam int SETTLE = 40;
   localparam int DELAY  = 100;
   localparam int MAXR   = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [1:0]       rst, start, wr_en, rd_en, wdone, ack, busy, cdone, cerr;
   logic [1:0][7:0]  addr, wdata, rdata, eidx;
   logic [1:0][31:0] dbg;

   // Instance 0: 3 entries, write only. Instance 1: 8 entries, verify, entry 1 is a delay.
   camera_cfg_seq #(
      .NUM_REGS(16'd3), .SETTLE_CYC(20'(SETTLE)), .DELAY_CYC(20'(DELAY)),
      .MAX_RETRY(3'(MAXR)), .VERIFY(1'b0), .ACK_OK(1'b0), .DELAY_ENTRY(8'hFF)
   ) u_dut_a (
      .clk(clk), .rst(rst[0]), .start(start[0]), .iic_wr_en(wr_en[0]), .iic_rd_en(rd_en[0]),
      .iic_addr(addr[0]), .iic_wr_data(wdata[0]), .iic_work_done(wdone[0]), .iic_ack(ack[0]),
      .iic_rd_data(rdata[0]), .cfg_busy(busy[0]), .cfg_done(cdone[0]), .cfg_err(cerr[0]),
      .err_index(eidx[0]), .debug_out(dbg[0])
   );

   camera_cfg_seq #(
      .NUM_REGS(16'd8), .SETTLE_CYC(20'(SETTLE)), .DELAY_CYC(20'(DELAY)),
      .MAX_RETRY(3'(MAXR)), .VERIFY(1'b1), .ACK_OK(1'b0), .DELAY_ENTRY(8'd1)
   ) u_dut_b (
      .clk(clk), .rst(rst[1]), .start(start[1]), .iic_wr_en(wr_en[1]), .iic_rd_en(rd_en[1]),
      .iic_addr(addr[1]), .iic_wr_data(wdata[1]), .iic_work_done(wdone[1]), .iic_ack(ack[1]),
      .iic_rd_data(rdata[1]), .cfg_busy(busy[1]), .cfg_done(cdone[1]), .cfg_err(cerr[1]),
      .err_index(eidx[1]), .debug_out(dbg[1])
   );

   // Driver model state and transfer log
   logic [1:0]      busy_m, op_m;
   logic [1:0][7:0] addr_m, data_m;
   int              cnt_m [2];
   logic [7:0]      mem [2][128];
   int              nack_used [2] = '{0, 0};
   int              n_xfer [2] = '{0, 0};
   logic            log_wr [2][256];
   logic [7:0]      log_addr [2][256];
   logic [7:0]      log_data [2][256];
   int              log_cyc [2][256];
   int              cyc = 0;
   int              both_cnt = 0;
   logic [7:0]      nack_addr [2];
   int              nack_limit [2];
   logic [1:0]      bad_rd;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      for (int g = 0; g < 2; g++) begin
         if (wr_en[g] && rd_en[g]) both_cnt <= both_cnt + 1;
         if (!rst[g]) begin
            busy_m[g] <= 1'b0;
            wdone[g]  <= 1'b0;
            ack[g]    <= 1'b0;
            rdata[g]  <= 8'd0;
            cnt_m[g]  <= 0;
         end else if (busy_m[g]) begin
            if (cnt_m[g] < XFER - 1) begin
               cnt_m[g] <= cnt_m[g] + 1;
            end else begin
               busy_m[g] <= 1'b0;
               wdone[g]  <= 1'b1;
               if (op_m[g]) begin
                  if (addr_m[g] == nack_addr[g] && nack_used[g] < nack_limit[g]) begin
                     ack[g]       <= 1'b1;
                     nack_used[g] <= nack_used[g] + 1;
                  end else begin
                     ack[g] <= 1'b0;
                     mem[g][addr_m[g][6:0]] <= data_m[g];
                  end
               end else begin
                  ack[g]   <= 1'b0;
                  rdata[g] <= bad_rd[g] ? 8'h12 : mem[g][addr_m[g][6:0]];
               end
            end
         end else if (wr_en[g] || rd_en[g]) begin
            busy_m[g] <= 1'b1;
            wdone[g]  <= 1'b0;
            cnt_m[g]  <= 0;
            op_m[g]   <= wr_en[g];
            addr_m[g] <= addr[g];
            data_m[g] <= wdata[g];
            log_wr[g][n_xfer[g] % 256]   <= wr_en[g];
            log_addr[g][n_xfer[g] % 256] <= addr[g];
            log_data[g][n_xfer[g] % 256] <= wdata[g];
            log_cyc[g][n_xfer[g] % 256]  <= cyc;
            n_xfer[g] <= n_xfer[g] + 1;
         end
      end
   end

   int checks = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected transfer list derived from the table and retry rules
   logic       e_wr [$];
   logic [7:0] e_addr [$];
   logic [7:0] e_data [$];
   logic       e_err;
   logic [7:0] e_eidx;

   task automatic predict(input int nr, input bit verify, input int dly_idx, input int nack_idx,
                          input int nack_n, input bit bad);
      e_wr.delete(); e_addr.delete(); e_data.delete();
      e_err  = 1'b0;
      e_eidx = 8'd0;
      for (int i = 0; i < nr; i++) begin
         logic [7:0] a, d;
         int         nacks;
         bit         ok;
         a     = i[7:0] & 8'h7F;
         d     = 8'(i * 3 + 'h13);
         nacks = (i == nack_idx) ? nack_n : 0;
         ok    = (i == dly_idx);
         for (int t = 0; t <= MAXR && !ok; t++) begin
            e_wr.push_back(1'b1); e_addr.push_back(a); e_data.push_back(d);
            ok = (t >= nacks);
            if (ok && verify) begin
               e_wr.push_back(1'b0); e_addr.push_back(a); e_data.push_back(d);
               ok = !bad;
            end
         end
         if (!ok) begin
            e_err  = 1'b1;
            e_eidx = i[7:0];
            return;
         end
      end
   endtask

   task automatic compare_log(input int g, input int base, input string tag);
      check({tag, "_count"}, n_xfer[g] - base, e_wr.size());
      for (int k = 0; k < e_wr.size() && k < n_xfer[g] - base; k++) begin
         check({tag, "_xfer"},
               {log_wr[g][(base + k) % 256], log_addr[g][(base + k) % 256],
                log_data[g][(base + k) % 256]},
               {e_wr[k], e_addr[k], e_data[k]});
      end
      check({tag, "_err"}, {cerr[g], cdone[g], busy[g]}, {e_err, !e_err, 1'b0});
      if (e_err) check({tag, "_eidx"}, eidx[g], e_eidx);
   endtask

   task automatic wait_end(input int g, input int budget, input string tag);
      int n = 0;
      while (!(cdone[g] || cerr[g]) && n < budget) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_timeout"}, cdone[g] || cerr[g], 1);
   endtask

   task automatic pulse_start(input int g);
      @(negedge clk);
      start[g] = 1'b1;
      @(negedge clk);
      start[g] = 1'b0;
   endtask

   function automatic logic [28:0] outs(input int g);
      return {wr_en[g], rd_en[g], addr[g], wdata[g], busy[g], cdone[g], cerr[g], eidx[g]};
   endfunction

   localparam logic [28:0] RST_OUTS = {1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00};

   initial begin
      int base, t0, n, hold;
      rst = 2'b00; start = 2'b00; bad_rd = 2'b00;
      nack_addr  = '{8'hEE, 8'hEE};
      nack_limit = '{0, 0};
      repeat (3) @(negedge clk);
      check("rst_outs_a", outs(0), RST_OUTS);
      check("rst_dbg_a", dbg[0], 32'h0);

      // 1: plain three-entry run
      base = n_xfer[0]; t0 = cyc; rst[0] = 1'b1;
      wait_end(0, 2000, "t1");
      predict(3, 0, 255, 255, 0, 0);
      compare_log(0, base, "t1");
      n = log_cyc[0][base % 256] - t0;
      check("t1_settle", (n >= SETTLE) && (n <= SETTLE + 4), 1);

      // 2: entry 1 NACKs twice
      nack_addr[0] = 8'd1; nack_limit[0] = nack_used[0] + 2;
      base = n_xfer[0];
      pulse_start(0);
      wait_end(0, 3000, "t2");
      predict(3, 0, 255, 1, 2, 0);
      compare_log(0, base, "t2");
      check("t2_retry_idx", dbg[0][23:12], {8'd3, 4'd0});

      // 3: entry 2 always NACKs
      nack_addr[0] = 8'd2; nack_limit[0] = nack_used[0] + 1000;
      base = n_xfer[0];
      pulse_start(0);
      wait_end(0, 3000, "t3");
      predict(3, 0, 255, 2, 1000, 0);
      compare_log(0, base, "t3");
      hold = n_xfer[0];
      repeat (200) @(negedge clk);
      check("t3_quiet", {n_xfer[0] - hold, 30'(wr_en[0]), rd_en[0]}, 32'h0);

      // 4: instance 1, delay marker at entry 1, readback correct
      base = n_xfer[1]; rst[1] = 1'b1;
      wait_end(1, 4000, "t4");
      predict(8, 1, 1, 255, 0, 0);
      compare_log(1, base, "t4");
      n = log_cyc[1][(base + 2) % 256] - log_cyc[1][base % 256];
      check("t4_gap", n >= DELAY + 2 * XFER, 1);

      // 5: readback always 8'h12 against written 8'h13
      bad_rd[1] = 1'b1;
      base = n_xfer[1];
      pulse_start(1);
      wait_end(1, 4000, "t5");
      predict(8, 1, 1, 255, 0, 1);
      compare_log(1, base, "t5");
      check("t5_last_rd", dbg[1][7:0], 8'h12);
      bad_rd[1] = 1'b0;

      // 6: reset during WR_WAIT of entry 5
      base = n_xfer[1];
      pulse_start(1);
      n = 0;
      while (n_xfer[1] < base + 9 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check("t6_reach5", n_xfer[1] >= base + 9, 1);
      repeat (5) @(negedge clk);
      check("t6_in_wr_wait", {addr[1], wr_en[1], rd_en[1], busy[1]}, {8'd5, 1'b0, 1'b0, 1'b1});
      rst[1] = 1'b0;
      #1;
      check("t6_rst_outs", outs(1), RST_OUTS);
      check("t6_rst_dbg", dbg[1], 32'h0);
      @(negedge clk);
      base = n_xfer[1]; t0 = cyc; rst[1] = 1'b1;
      n = 0;
      while (n_xfer[1] == base && n < 500) begin
         @(negedge clk);
         n++;
      end
      check("t6_restart_xfer",
            {log_wr[1][base % 256], log_addr[1][base % 256], log_data[1][base % 256]},
            {1'b1, 8'h00, 8'h13});
      n = log_cyc[1][base % 256] - t0;
      check("t6_settle", (n >= SETTLE) && (n <= SETTLE + 4), 1);

      check("never_both_en", both_cnt, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
